// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LOAD = 3'd7;
  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h42;
  localparam logic RW_READ = 1'b1;
  localparam logic I2C_ACK = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                      input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - application-side byte handshake of the I2C target
interface i2c_target_if;
  import i2c_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_req;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data,
    input  tx_req,
    input  rx_data,
    input  rx_valid,
    input  busy
  );

  modport slave (
    input  tx_data,
    output tx_req,
    output rx_data,
    output rx_valid,
    output busy
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-flop synchronizer with rise/fall detect for one bus line
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset high so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target (7-bit address) with byte-wide read/write handshake
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire          i2c_scl,
  inout  wire          i2c_sda,
  i2c_target_if.slave  app
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (i2c_scl),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (i2c_sda),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  state_t                 state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-1:0]      shift_q;
  logic [BYTE_W-1:0]      shift_d;
  logic [BYTE_W-1:0]      rx_data_q;
  logic                   sda_oe_q;
  logic                   phase_q;
  logic                   rw_q;
  logic                   busy_q;
  logic                   rx_valid_q;
  logic                   tx_req_q;
  logic                   start_det;
  logic                   stop_det;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};

  // Open drain: the pad only ever pulls low; reset clears sda_oe_q asynchronously.
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

  assign app.tx_req   = tx_req_q;
  assign app.rx_data  = rx_data_q;
  assign app.rx_valid = rx_valid_q;
  assign app.busy     = busy_q;

  // phase_q splits each ACK slot into "drive/await" and "finish at next SCL fall".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= BIT_CNT_LOAD;
        sda_oe_q  <= 1'b0;
        phase_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        phase_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
          end
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q - 3'd1;
              if (bit_cnt_q == '0) begin
                if (addr_match(shift_d, TARGET_ADDR)) begin
                  state_q <= ST_ADDR_ACK;
                  rw_q    <= shift_d[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= BIT_CNT_LOAD;
                if (rw_q == RW_READ) begin
                  shift_q  <= app.tx_data;
                  tx_req_q <= 1'b1;
                  sda_oe_q <= ~app.tx_data[BYTE_W-1];
                  state_q  <= ST_RD_DATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= ST_WR_DATA;
                end
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q - 3'd1;
              if (bit_cnt_q == '0) begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
                state_q    <= ST_WR_ACK;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                phase_q   <= 1'b0;
                bit_cnt_q <= BIT_CNT_LOAD;
                state_q   <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == '0) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                shift_q   <= {shift_q[BYTE_W-2:0], 1'b0};
                sda_oe_q  <= ~shift_q[BYTE_W-2];
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (!phase_q && scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                shift_q  <= app.tx_data;
                tx_req_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (phase_q && scl_fall) begin
              phase_q   <= 1'b0;
              bit_cnt_q <= BIT_CNT_LOAD;
              sda_oe_q  <= ~shift_q[BYTE_W-1];
              state_q   <= ST_RD_DATA;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clk;
  logic rst;
  logic scl_drv;
  logic sda_drv;
  wire  i2c_scl;
  wire  i2c_sda;
  int   checks;
  int   errors;
  int   rxv_cnt;
  int   txr_cnt;

  i2c_target_if app_if ();

  assign i2c_scl = scl_drv;
  assign i2c_sda = sda_drv ? 1'bz : 1'b0;
  pullup (i2c_sda);

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_scl (i2c_scl),
    .i2c_sda (i2c_sda),
    .app     (app_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (app_if.rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
    if (app_if.tx_req === 1'b1) txr_cnt <= txr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    tick(Q);
    scl_drv = 1'b1;
    tick(Q);
    sda_drv = 1'b0;
    tick(Q);
    scl_drv = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    tick(Q);
    scl_drv = 1'b1;
    tick(Q);
    sda_drv = 1'b1;
    tick(Q);
  endtask

  task automatic bit_clock(input logic b, output logic sampled);
    sda_drv = b;
    tick(Q);
    scl_drv = 1'b1;
    tick(Q / 2);
    sampled = i2c_sda;
    tick(Q / 2);
    scl_drv = 1'b0;
    tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clock(b[i], s);
    bit_clock(1'b1, ack);
  endtask

  task automatic read_byte(input logic [7:0] next_tx, input logic m_ack,
                           output logic [7:0] d, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clock(1'b1, s);
      d[i] = s;
    end
    app_if.tx_data = next_tx;
    bit_clock(m_ack, ack_line);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         rxv0;
    int         txr0;

    checks  = 0;
    errors  = 0;
    rxv_cnt = 0;
    txr_cnt = 0;
    rst     = 1'b1;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    app_if.tx_data = 8'h00;
    tick(3);
    check("rst_busy", 32'(app_if.busy), 32'd0);
    check("rst_rx_valid", 32'(app_if.rx_valid), 32'd0);
    check("rst_tx_req", 32'(app_if.tx_req), 32'd0);
    check("rst_rx_data", 32'(app_if.rx_data), 32'h00);
    check("rst_sda", 32'(i2c_sda), 32'd1);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    tick(Q);

    // Write 0x42 / 0xA5 / STOP
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    check("wr_busy", 32'(app_if.busy), 32'd1);
    write_byte(8'hA5, ack);
    check("wr_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    tick(4);
    check("wr_rx_data", 32'(app_if.rx_data), 32'hA5);
    check("wr_rx_valid_cnt", 32'(rxv_cnt - rxv0), 32'd1);
    check("wr_busy_after_stop", 32'(app_if.busy), 32'd0);

    // Write to a foreign address
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h86, ack);
    check("bad_addr_nack", 32'(ack), 32'd1);
    check("bad_addr_busy", 32'(app_if.busy), 32'd0);
    i2c_stop();
    tick(4);
    check("bad_addr_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    app_if.tx_data = 8'h3C;
    txr0 = txr_cnt;
    i2c_start();
    write_byte(8'h85, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(8'hC3, 1'b0, d, s);
    check("rd_byte0", 32'(d), 32'h3C);
    read_byte(8'h00, 1'b1, d, s);
    check("rd_byte1", 32'(d), 32'hC3);
    check("rd_nack_line", 32'(s), 32'd1);
    tick(4);
    check("rd_sda_released", 32'(i2c_sda), 32'd1);
    i2c_stop();
    tick(4);
    check("rd_tx_req_cnt", 32'(txr_cnt - txr0), 32'd2);
    check("rd_busy_after_stop", 32'(app_if.busy), 32'd0);

    // Write 0x10 then repeated START read
    i2c_start();
    write_byte(8'h84, ack);
    check("rs_wr_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h10, ack);
    check("rs_wr_data_ack", 32'(ack), 32'd0);
    check("rs_rx_data", 32'(app_if.rx_data), 32'h10);
    app_if.tx_data = 8'h96;
    i2c_start();
    write_byte(8'h85, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'd0);
    read_byte(8'h00, 1'b1, d, s);
    check("rs_rd_byte", 32'(d), 32'h96);
    i2c_stop();
    tick(4);

    // Reset during bit 4 of a read byte of zeros
    app_if.tx_data = 8'h00;
    i2c_start();
    write_byte(8'h85, ack);
    check("rst_rd_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) bit_clock(1'b1, s);
    tick(3);
    check("rst_rd_driving", 32'(i2c_sda), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_sda", 32'(i2c_sda), 32'd1);
    check("rst_mid_busy", 32'(app_if.busy), 32'd0);
    check("rst_mid_rx_data", 32'(app_if.rx_data), 32'h00);
    check("rst_mid_tx_req", 32'(app_if.tx_req), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) bit_clock(1'b0, s);
    check("rst_ignore_state", 32'(dut.state_q), 32'(ST_IDLE));
    i2c_stop();
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h5A, ack);
    check("post_rst_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    tick(4);
    check("post_rst_rx_data", 32'(app_if.rx_data), 32'h5A);
    check("post_rst_rx_valid", 32'(rxv_cnt - rxv0), 32'd1);

    // STOP after 3 bits of a write byte
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("abort_addr_ack", 32'(ack), 32'd0);
    bit_clock(1'b1, s);
    bit_clock(1'b0, s);
    bit_clock(1'b1, s);
    i2c_stop();
    tick(4);
    check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("abort_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);
    check("abort_sda", 32'(i2c_sda), 32'd1);
    check("abort_busy", 32'(app_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
